// File: rtl/receiver_i2c.sv
// receiver_i2c: I2C target that sits behind the transmitter_I2C master.
// It decodes START/STOP, matches a 7-bit address, and moves one 16-bit word per
// transfer (two bytes, MSB first).
//   clk, rst        system clock, synchronous active-high reset
//   SCL             bus clock from the master
//   SDA_OUT/SDA_OE  master SDA value and drive enable
//   SDA_IN          target SDA value (0 = pull low, 1 = release)
//   SDA_IN_ACK      high for the whole ACK slot when the target ACKs
//   RD_DATA/RD_STB  read word source and its capture strobe
//   WR_DATA/WR_VALID last written word and its update strobe
//   BUSY            transfer in progress (state != IDLE)
//
// state     | meaning
// IDLE      | bus idle, waiting for START
// ADDR      | shifting in the address byte
// ADDR_ACK  | driving ACK for the matched address
// WR_BYTE   | shifting in a write data byte
// WR_ACK    | driving ACK for a write data byte
// RD_BYTE   | presenting read data bits on SCL falls
// RD_ACK    | sampling the master's ACK/NACK
// WAIT_STOP | transfer done, SDA released until STOP/START
module receiver_i2c #(
  parameter logic [6:0] ADDR = 7'h2A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SCL,
  input  logic        SDA_OUT,
  input  logic        SDA_OE,
  output logic        SDA_IN,
  output logic        SDA_IN_ACK,
  input  logic [15:0] RD_DATA,
  output logic [15:0] WR_DATA,
  output logic        WR_VALID,
  output logic        RD_STB,
  output logic        BUSY
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_WAIT_STOP
  } state_t;

  state_t      state_q, state_d;
  logic        scl_q, sda_q;
  logic [15:0] sh_q, sh_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d, bit_inc;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic        rnw_q, rnw_d;
  logic        ack_q, ack_d;           // 1 = ACK currently being driven
  logic        sda_in_q, sda_in_d;
  logic        sda_ack_q, sda_ack_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        wr_valid_q, wr_valid_d;
  logic        rd_stb_q, rd_stb_d;

  logic sda, scl_rise, scl_fall, start_c, stop_c;

  // The target's own drive is part of the bus value when the master releases SDA.
  assign sda      = SDA_OE ? SDA_OUT : sda_in_q;
  assign scl_rise = SCL & ~scl_q;
  assign scl_fall = ~SCL & scl_q;
  assign start_c  = scl_q & SCL & sda_q & ~sda;
  assign stop_c   = scl_q & SCL & ~sda_q & sda;
  assign bit_inc  = (bit_cnt_q == 4'd8) ? 4'd8 : bit_cnt_q + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      sh_q       <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      rnw_q      <= 1'b0;
      ack_q      <= 1'b0;
      sda_in_q   <= 1'b1;
      sda_ack_q  <= 1'b0;
      wr_data_q  <= '0;
      wr_valid_q <= 1'b0;
      rd_stb_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      scl_q      <= SCL;
      sda_q      <= sda;
      sh_q       <= sh_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      rnw_q      <= rnw_d;
      ack_q      <= ack_d;
      sda_in_q   <= sda_in_d;
      sda_ack_q  <= sda_ack_d;
      wr_data_q  <= wr_data_d;
      wr_valid_q <= wr_valid_d;
      rd_stb_q   <= rd_stb_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    rnw_d      = rnw_q;
    ack_d      = ack_q;
    sda_in_d   = sda_in_q;
    sda_ack_d  = sda_ack_q;
    wr_data_d  = wr_data_q;
    wr_valid_d = 1'b0;
    rd_stb_d   = 1'b0;

    // START wins over any coincident SCL edge.
    if (start_c) begin
      state_d    = S_ADDR;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
      ack_d      = 1'b0;
      sda_in_d   = 1'b1;
      sda_ack_d  = 1'b0;
    end else if (stop_c && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      ack_d     = 1'b0;
      sda_in_d  = 1'b1;
      sda_ack_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_ADDR: if (scl_rise) begin
          sh_d      = {sh_q[14:0], sda};
          bit_cnt_d = bit_inc;
          if (bit_cnt_q == 4'd7) begin
            if (sh_d[7:1] == ADDR) begin
              state_d = S_ADDR_ACK;
              rnw_d   = sda;
              ack_d   = 1'b0;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_ADDR_ACK: if (scl_fall) begin
          if (!ack_q) begin
            ack_d     = 1'b1;
            sda_in_d  = 1'b0;
            sda_ack_d = 1'b1;
            if (rnw_q) begin
              sh_d     = RD_DATA;
              rd_stb_d = 1'b1;
            end
          end else begin
            ack_d     = 1'b0;
            sda_ack_d = 1'b0;
            if (rnw_q) begin
              // First read bit goes out on the same fall that ends the ACK slot.
              state_d   = S_RD_BYTE;
              sda_in_d  = sh_q[15];
              sh_d      = {sh_q[14:0], 1'b0};
              bit_cnt_d = 4'd1;
            end else begin
              state_d   = S_WR_BYTE;
              sda_in_d  = 1'b1;
              bit_cnt_d = '0;
            end
          end
        end
        S_WR_BYTE: if (scl_rise) begin
          sh_d      = {sh_q[14:0], sda};
          bit_cnt_d = bit_inc;
          if (bit_cnt_q == 4'd7) begin
            ack_d   = 1'b0;
            state_d = (byte_cnt_q == 2'd2) ? S_WAIT_STOP : S_WR_ACK;
          end
        end
        S_WR_ACK: if (scl_fall) begin
          if (!ack_q) begin
            ack_d      = 1'b1;
            sda_in_d   = 1'b0;
            sda_ack_d  = 1'b1;
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd1) begin
              wr_data_d  = sh_q;
              wr_valid_d = 1'b1;
            end
          end else begin
            ack_d     = 1'b0;
            sda_in_d  = 1'b1;
            sda_ack_d = 1'b0;
            bit_cnt_d = '0;
            state_d   = (byte_cnt_q == 2'd2) ? S_WAIT_STOP : S_WR_BYTE;
          end
        end
        S_RD_BYTE: if (scl_fall) begin
          if (bit_cnt_q < 4'd8) begin
            sda_in_d  = sh_q[15];
            sh_d      = {sh_q[14:0], 1'b0};
            bit_cnt_d = bit_inc;
          end else begin
            sda_in_d = 1'b1;
            state_d  = S_RD_ACK;
          end
        end
        S_RD_ACK: if (scl_rise) begin
          if (!sda && byte_cnt_q < 2'd1) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            bit_cnt_d  = '0;
            state_d    = S_RD_BYTE;
          end else begin
            state_d = S_WAIT_STOP;
          end
        end
        S_WAIT_STOP: sda_in_d = 1'b1;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign SDA_IN     = sda_in_q;
  assign SDA_IN_ACK = sda_ack_q;
  assign WR_DATA    = wr_data_q;
  assign WR_VALID   = wr_valid_q;
  assign RD_STB     = rd_stb_q;
  assign BUSY       = (state_q != S_IDLE);

endmodule

// File: tb/tb_receiver_i2c.sv
module tb_receiver_i2c;

  logic        clk = 1'b0;
  logic        rst;
  logic        SCL, SDA_OUT, SDA_OE;
  logic        SDA_IN, SDA_IN_ACK;
  logic [15:0] RD_DATA;
  logic [15:0] WR_DATA;
  logic        WR_VALID, RD_STB, BUSY;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;

  receiver_i2c dut (
    .clk(clk), .rst(rst), .SCL(SCL), .SDA_OUT(SDA_OUT), .SDA_OE(SDA_OE),
    .SDA_IN(SDA_IN), .SDA_IN_ACK(SDA_IN_ACK), .RD_DATA(RD_DATA),
    .WR_DATA(WR_DATA), .WR_VALID(WR_VALID), .RD_STB(RD_STB), .BUSY(BUSY)
  );

  always #5 clk = ~clk;

  // Pulse cycle counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (WR_VALID) wr_cnt++;
    if (RD_STB) rd_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    SDA_OE = 1'b1; SDA_OUT = 1'b1; tick(4);
    SCL = 1'b1; tick(4);
    SDA_OUT = 1'b0; tick(4);
    SCL = 1'b0; tick(2);
  endtask

  task automatic bus_stop();
    SDA_OE = 1'b1; SDA_OUT = 1'b0; tick(4);
    SCL = 1'b1; tick(4);
    SDA_OUT = 1'b1; tick(4);
  endtask

  task automatic send_bit(input logic b);
    SDA_OE = 1'b1; SDA_OUT = b; tick(4);
    SCL = 1'b1; tick(4);
    SCL = 1'b0; tick(2);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  // Released slot: returns the SDA_IN and SDA_IN_ACK values seen mid-high.
  task automatic read_slot(output logic v, output logic f);
    SDA_OE = 1'b0; tick(4);
    SCL = 1'b1; tick(2);
    v = SDA_IN; f = SDA_IN_ACK; tick(2);
    SCL = 1'b0; tick(2);
  endtask

  task automatic read_byte(output logic [7:0] b);
    logic v, f;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      read_slot(v, f);
      b = {b[6:0], v};
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; SCL = 1'b1; SDA_OUT = 1'b1; SDA_OE = 1'b1; RD_DATA = '0;
    tick(3);
    checks++; if (SDA_IN !== 1'b1) begin errors++; $display("FAIL reset_sda_in got %b exp 1", SDA_IN); end
    checks++; if (SDA_IN_ACK !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", SDA_IN_ACK); end
    checks++; if (WR_DATA !== 16'h0000) begin errors++; $display("FAIL reset_wr_data got %h exp 0000", WR_DATA); end
    checks++; if (WR_VALID !== 1'b0 || RD_STB !== 1'b0) begin errors++; $display("FAIL reset_pulses got %b%b exp 00", WR_VALID, RD_STB); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", BUSY); end
    rst = 1'b0;
    tick(4);
  endtask

  task automatic test_write(input logic [15:0] w, input string nm);
    logic a, f;
    int w0, r0;
    w0 = wr_cnt; r0 = rd_cnt;
    bus_start();
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL %s busy_after_start got %b exp 1", nm, BUSY); end
    send_byte(8'h54);
    read_slot(a, f);
    checks++; if (a !== 1'b0 || f !== 1'b1) begin errors++; $display("FAIL %s addr_ack got sda=%b ack=%b exp sda=0 ack=1", nm, a, f); end
    send_byte(w[15:8]);
    read_slot(a, f);
    checks++; if (a !== 1'b0 || f !== 1'b1) begin errors++; $display("FAIL %s byte1_ack got sda=%b ack=%b exp sda=0 ack=1", nm, a, f); end
    send_byte(w[7:0]);
    read_slot(a, f);
    checks++; if (a !== 1'b0 || f !== 1'b1) begin errors++; $display("FAIL %s byte2_ack got sda=%b ack=%b exp sda=0 ack=1", nm, a, f); end
    checks++; if (WR_DATA !== w) begin errors++; $display("FAIL %s wr_data got %h exp %h", nm, WR_DATA, w); end
    bus_stop();
    checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL %s wr_valid_cycles got %0d exp 1", nm, wr_cnt - w0); end
    checks++; if (rd_cnt - r0 !== 0) begin errors++; $display("FAIL %s rd_stb_cycles got %0d exp 0", nm, rd_cnt - r0); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL %s busy_after_stop got %b exp 0", nm, BUSY); end
  endtask

  task automatic test_read();
    logic a, f;
    logic [7:0] b;
    int w0, r0;
    w0 = wr_cnt; r0 = rd_cnt;
    RD_DATA = 16'hBEEF;
    bus_start();
    send_byte(8'h55);
    read_slot(a, f);
    checks++; if (a !== 1'b0 || f !== 1'b1) begin errors++; $display("FAIL rd_addr_ack got sda=%b ack=%b exp sda=0 ack=1", a, f); end
    read_byte(b);
    checks++; if (b !== 8'hBE) begin errors++; $display("FAIL rd_byte1 got %h exp be", b); end
    send_bit(1'b0);
    read_byte(b);
    checks++; if (b !== 8'hEF) begin errors++; $display("FAIL rd_byte2 got %h exp ef", b); end
    send_bit(1'b1);
    checks++; if (SDA_IN !== 1'b1) begin errors++; $display("FAIL rd_release_after_nack got %b exp 1", SDA_IN); end
    bus_stop();
    checks++; if (rd_cnt - r0 !== 1) begin errors++; $display("FAIL rd_stb_cycles got %0d exp 1", rd_cnt - r0); end
    checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL rd_wr_valid_cycles got %0d exp 0", wr_cnt - w0); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rd_busy_after_stop got %b exp 0", BUSY); end
  endtask

  task automatic test_addr_mismatch();
    logic a, f;
    int w0, r0;
    w0 = wr_cnt; r0 = rd_cnt;
    bus_start();
    send_byte(8'h26);
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL nomatch_busy got %b exp 0", BUSY); end
    read_slot(a, f);
    checks++; if (a !== 1'b1 || f !== 1'b0) begin errors++; $display("FAIL nomatch_ack_slot got sda=%b ack=%b exp sda=1 ack=0", a, f); end
    bus_stop();
    checks++; if (wr_cnt - w0 !== 0 || rd_cnt - r0 !== 0) begin errors++; $display("FAIL nomatch_pulses got wr=%0d rd=%0d exp 0 0", wr_cnt - w0, rd_cnt - r0); end
  endtask

  task automatic test_stop_partial();
    logic a, f;
    int w0;
    w0 = wr_cnt;
    bus_start();
    send_byte(8'h54);
    read_slot(a, f);
    send_byte(8'h12);
    read_slot(a, f);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL partial_byte_ack got %b exp 0", a); end
    bus_stop();
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL partial_busy got %b exp 0", BUSY); end
    checks++; if (WR_DATA !== 16'hA55A) begin errors++; $display("FAIL partial_wr_data got %h exp a55a", WR_DATA); end
    checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL partial_wr_valid got %0d exp 0", wr_cnt - w0); end
  endtask

  task automatic test_repeated_start();
    logic a, f;
    logic [7:0] b;
    RD_DATA = 16'hBEEF;
    bus_start();
    send_byte(8'h55);
    read_slot(a, f);
    read_byte(b);
    checks++; if (b !== 8'hBE) begin errors++; $display("FAIL rs_read_byte got %h exp be", b); end
    send_bit(1'b0);
    read_slot(a, f);
    read_slot(a, f);
    test_write(16'h0001, "rs_write");
  endtask

  task automatic test_reset_mid_read();
    logic a, f;
    RD_DATA = 16'hBEEF;
    bus_start();
    send_byte(8'h55);
    read_slot(a, f);
    read_slot(a, f);
    checks++; if (SDA_IN !== 1'b0) begin errors++; $display("FAIL rstmid_pre_drive got %b exp 0", SDA_IN); end
    rst = 1'b1;
    tick(1);
    checks++; if (SDA_IN !== 1'b1) begin errors++; $display("FAIL rstmid_sda_in got %b exp 1", SDA_IN); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", BUSY); end
    rst = 1'b0;
    SDA_OE = 1'b1; SDA_OUT = 1'b1; tick(4);
    SCL = 1'b1; tick(4);
    checks++; if (BUSY !== 1'b0 || SDA_IN !== 1'b1) begin errors++; $display("FAIL rstmid_idle got busy=%b sda=%b exp 0 1", BUSY, SDA_IN); end
  endtask

  initial begin
    test_reset();
    test_write(16'hA55A, "write");
    test_read();
    test_addr_mismatch();
    test_stop_partial();
    test_repeated_start();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
